// File: rtl/m_ext_pkg.sv
// Shared RV32M execute-stage definitions: operand width, multiply/divide op
// selects and the iterative-unit state encoding.
package m_ext_pkg;

  parameter int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    MS_NONE   = 3'b000,
    MS_MUL    = 3'b001,
    MS_MULH   = 3'b010,
    MS_MULHSU = 3'b011,
    MS_MULHU  = 3'b100
  } mulsel_e;

  typedef enum logic [2:0] {
    DS_NONE = 3'b000,
    DS_DIV  = 3'b001,
    DS_DIVU = 3'b010,
    DS_REM  = 3'b011,
    DS_REMU = 3'b100
  } divsel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    DONE1 = 2'b10,
    DONE2 = 2'b11
  } state_e;

  function automatic logic mulsel_valid(input logic [2:0] sel);
    return (sel >= 3'b001) && (sel <= 3'b100);
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/select/ready/result bundle shared by the iterative M-extension units.
interface seq_multiplier_if #(
  parameter int XLEN = 32
);
  logic [2:0]      mulsel;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            ready;
  logic [XLEN-1:0] res;

  modport master (output mulsel, a, b, input ready, res);
  modport slave  (input mulsel, a, b, output ready, res);
endinterface

// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU with a
// fixed XLEN-cycle iteration phase followed by a two-cycle ready pulse.
module seq_multiplier
  import m_ext_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  seq_multiplier_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  state_e              state_q, state_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [XLEN-1:0]     ma_q, ma_d;
  logic [XLEN-1:0]     mb_q, mb_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic                hi_sel_q, hi_sel_d;
  logic                ready_q, ready_d;
  logic [XLEN-1:0]     res_q, res_d;

  mulsel_e             op;
  logic                op_valid;
  logic [XLEN:0]       sum;
  logic [2*XLEN-1:0]   prod_next;
  logic [2*XLEN-1:0]   prod_final;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      prod_q   <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_sel_q <= 1'b0;
      ready_q  <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      prod_q   <= prod_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      hi_sel_q <= hi_sel_d;
      ready_q  <= ready_d;
      res_q    <= res_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prod_d   = prod_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    hi_sel_d = hi_sel_q;
    ready_d  = ready_q;
    res_d    = res_q;

    op       = mulsel_e'(bus.mulsel);
    op_valid = mulsel_valid(bus.mulsel);

    // Carry out of the upper-half add lands in the MSB after the shift.
    sum        = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (mb_q[0] ? ma_q : '0)};
    prod_next  = (2*XLEN)'({sum, prod_q[XLEN-1:0]} >> 1);
    prod_final = neg_q ? (~prod_next + 1'b1) : prod_next;

    case (state_q)
      IDLE: begin
        if (op_valid) begin
          state_d  = BUSY;
          ma_d     = ((op == MS_MULH || op == MS_MULHSU) && bus.a[XLEN-1])
                     ? (~bus.a + 1'b1) : bus.a;
          mb_d     = ((op == MS_MULH) && bus.b[XLEN-1]) ? (~bus.b + 1'b1) : bus.b;
          neg_d    = ((op == MS_MULH) && (bus.a[XLEN-1] ^ bus.b[XLEN-1])) ||
                     ((op == MS_MULHSU) && bus.a[XLEN-1]);
          hi_sel_d = (op != MS_MUL);
          prod_d   = '0;
          cnt_d    = CW'(XLEN - 1);
        end
      end
      BUSY: begin
        if (!op_valid) begin
          state_d = IDLE;
        end else begin
          prod_d = prod_next;
          mb_d   = mb_q >> 1;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = DONE1;
            res_d   = hi_sel_q ? prod_final[2*XLEN-1:XLEN] : prod_final[XLEN-1:0];
            ready_d = 1'b1;
          end
        end
      end
      DONE1: state_d = DONE2;
      DONE2: begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready = ready_q;
  assign bus.res   = res_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier.
module tb_seq_multiplier;

  localparam int XLEN = 32;
  localparam int LAT  = 32;   // posedges from start edge to the edge that raises ready
  localparam int TMO  = 100;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  seq_multiplier_if #(.XLEN(XLEN)) bus ();

  seq_multiplier #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: start an op, scramble operands mid-BUSY, measure latency and pulse width.
  task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output int width);
    @(negedge clk);
    bus.mulsel = op;
    bus.a      = av;
    bus.b      = bv;
    @(posedge clk);
    lat = 0;
    while (lat < TMO) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 5) begin
        bus.a = 32'hDEAD_BEEF;
        bus.b = 32'h1357_9BDF;
      end
      if (bus.ready) break;
    end
    @(negedge clk);
    bus.mulsel = 3'b000;
    width = bus.ready ? 1 : 0;
    @(posedge clk); #1;
    if (bus.ready) width++;
    @(posedge clk); #1;
    if (bus.ready) width++;
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    bus.mulsel = 3'b001;
    bus.a      = 32'd3;
    bus.b      = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0", bus.ready);
    end
    n_checks++;
    if (bus.res !== 32'h0) begin
      n_fail++; $display("FAIL reset_res: got %h want 00000000", bus.res);
    end
    @(negedge clk);
    bus.mulsel = 3'b000;
    rst        = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    n_checks++;
    if (bus.ready !== 1'b0 || bus.res !== 32'h0) begin
      n_fail++; $display("FAIL reset_wins: got ready=%b res=%h want 0/00000000", bus.ready, bus.res);
    end
  endtask

  task automatic test_mul_latency;
    int lat, width;
    run_op(3'b001, 32'd7, 32'hFFFF_FFFD, lat, width);
    n_checks++;
    if (lat !== LAT) begin
      n_fail++; $display("FAIL mul_latency: got %0d want %0d", lat, LAT);
    end
    n_checks++;
    if (width !== 2) begin
      n_fail++; $display("FAIL mul_ready_width: got %0d want 2", width);
    end
    n_checks++;
    if (bus.res !== 32'hFFFF_FFEB) begin
      n_fail++; $display("FAIL mul_res: got %h want ffffffeb", bus.res);
    end
  endtask

  task automatic test_mulh;
    int lat, width;
    run_op(3'b010, 32'h8000_0000, 32'h8000_0000, lat, width);
    n_checks++;
    if (bus.res !== 32'h4000_0000 || lat !== LAT) begin
      n_fail++; $display("FAIL mulh_minmin: got res=%h lat=%0d want 40000000/%0d", bus.res, lat, LAT);
    end
    run_op(3'b010, 32'hFFFF_FFFF, 32'd1, lat, width);
    n_checks++;
    if (bus.res !== 32'hFFFF_FFFF || width !== 2) begin
      n_fail++; $display("FAIL mulh_neg1: got res=%h width=%0d want ffffffff/2", bus.res, width);
    end
  endtask

  task automatic test_mulhsu_mulhu;
    int lat, width;
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, width);
    n_checks++;
    if (bus.res !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL mulhsu: got %h want ffffffff", bus.res);
    end
    run_op(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, width);
    n_checks++;
    if (bus.res !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL mulhu: got %h want fffffffe", bus.res);
    end
  endtask

  task automatic test_zero_no_early_exit;
    int lat, width;
    run_op(3'b100, 32'h0, 32'h1234_5678, lat, width);
    n_checks++;
    if (lat !== LAT) begin
      n_fail++; $display("FAIL zero_latency: got %0d want %0d", lat, LAT);
    end
    n_checks++;
    if (bus.res !== 32'h0) begin
      n_fail++; $display("FAIL zero_res: got %h want 00000000", bus.res);
    end
  endtask

  task automatic test_abort;
    int lat, width, seen;
    logic [31:0] prev;
    prev = bus.res;
    @(negedge clk);
    bus.mulsel = 3'b001;
    bus.a      = 32'd3;
    bus.b      = 32'd5;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.mulsel = 3'b000;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.ready) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL abort_no_ready: got %0d ready cycles want 0", seen);
    end
    n_checks++;
    if (bus.res !== prev) begin
      n_fail++; $display("FAIL abort_res_held: got %h want %h", bus.res, prev);
    end
    run_op(3'b001, 32'd3, 32'd5, lat, width);
    n_checks++;
    if (bus.res !== 32'd15 || lat !== LAT) begin
      n_fail++; $display("FAIL abort_restart: got res=%h lat=%0d want 0000000f/%0d", bus.res, lat, LAT);
    end
  endtask

  task automatic test_reset_mid_op;
    int lat, width, cnt;
    // mid-BUSY
    @(negedge clk);
    bus.mulsel = 3'b100;
    bus.a      = 32'hFFFF_FFFF;
    bus.b      = 32'hFFFF_FFFF;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.ready !== 1'b0 || bus.res !== 32'h0) begin
      n_fail++; $display("FAIL rst_busy: got ready=%b res=%h want 0/00000000", bus.ready, bus.res);
    end
    @(negedge clk);
    rst = 1'b0;
    // mid-DONE1
    @(posedge clk);
    cnt = 0;
    while (cnt < TMO) begin
      @(posedge clk); #1;
      cnt++;
      if (bus.ready) break;
    end
    n_checks++;
    if (cnt !== LAT) begin
      n_fail++; $display("FAIL rst_done1_setup: got lat=%0d want %0d", cnt, LAT);
    end
    #2 rst = 1'b1;
    bus.mulsel = 3'b000;
    #1;
    n_checks++;
    if (bus.ready !== 1'b0 || bus.res !== 32'h0) begin
      n_fail++; $display("FAIL rst_done1: got ready=%b res=%h want 0/00000000", bus.ready, bus.res);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(3'b100, 32'h0001_0000, 32'h0001_0000, lat, width);
    n_checks++;
    if (bus.res !== 32'h1 || width !== 2) begin
      n_fail++; $display("FAIL rst_recover_mulhu: got res=%h width=%0d want 00000001/2", bus.res, width);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    bus.mulsel = 3'b000;
    bus.a      = '0;
    bus.b      = '0;
    test_reset;
    test_mul_latency;
    test_mulh;
    test_mulhsu_mulhu;
    test_zero_no_early_exit;
    test_abort;
    test_reset_mid_op;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
